// File: rtl/fta_bus_pkg.sv
// FTA bus payload types, plus the queue entry and FSM state used by the
// FTA-to-Wishbone bridge.
package fta_bus_pkg;

  localparam int unsigned FTA_DW = 256;
  localparam int unsigned FTA_SW = FTA_DW / 8;
  localparam int unsigned FTA_AW = 32;
  localparam int unsigned FTA_TW = 8;

  typedef enum logic [3:0] {
    CMD_NONE  = 4'd0,
    CMD_LOAD  = 4'd1,
    CMD_STORE = 4'd2
  } fta_cmd_t;

  typedef enum logic [1:0] {
    OKAY = 2'd0,
    ERR  = 2'd2
  } fta_status_t;

  typedef struct packed {
    logic              cyc;
    fta_cmd_t          cmd;
    logic              we;
    logic [FTA_SW-1:0] sel;
    logic [FTA_AW-1:0] adr;
    logic [FTA_DW-1:0] data1;
    logic [FTA_TW-1:0] tid;
  } fta_cmd_request256_t;

  typedef struct packed {
    logic              ack;
    logic              rty;
    logic              err;
    logic              stall;
    logic [FTA_TW-1:0] tid;
    logic [FTA_TW-1:0] rty_tid;
    logic [FTA_AW-1:0] adr;
    logic [FTA_DW-1:0] dat;
  } fta_cmd_response256_t;

  typedef struct packed {
    fta_cmd_t          cmd;
    logic              we;
    logic [FTA_SW-1:0] sel;
    logic [FTA_AW-1:0] adr;
    logic [FTA_DW-1:0] dat;
    logic [FTA_TW-1:0] tid;
  } fta_wb_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } fta_wb_state_t;

  function automatic fta_wb_entry_t fta_wb_entry_from_req(input fta_cmd_request256_t r);
    fta_wb_entry_t e;
    e.cmd = r.cmd;
    e.we  = r.we;
    e.sel = r.sel;
    e.adr = r.adr;
    e.dat = r.data1;
    e.tid = r.tid;
    return e;
  endfunction

endpackage

// File: rtl/fta_bus_interface.sv
// FTA request/response channel pair between an FTA initiator and a target.
interface fta_bus_interface;
  import fta_bus_pkg::*;

  fta_cmd_request256_t  req;
  fta_cmd_response256_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/fta_wb_req_fifo.sv
// Small circular request queue; pushes while full are accepted only if a pop
// happens on the same edge.
module fta_wb_req_fifo
  import fta_bus_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = fta_wb_entry_t,
  localparam int unsigned PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  entry_t        din_i,
  input  logic          pop_i,
  output entry_t        head_c,
  output logic          full_c,
  output logic          empty_c,
  output logic [CW-1:0] count_o
);

  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic          do_push, do_pop;

  assign full_c  = (cnt_q == CW'(DEPTH));
  assign empty_c = (cnt_q == '0);
  assign head_c  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign do_pop  = pop_i && !empty_c;
  assign do_push = push_i && (!full_c || do_pop);

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wr_q] = din_i;
      wr_d        = wr_q + PW'(1);
    end
    if (do_pop) rd_d = rd_q + PW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by cnt_q.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fta_to_wb_bridge.sv
// FTA target that queues request beats and replays each as a classic
// Wishbone master cycle, returning FTA ack/err/rty/stall responses.
module fta_to_wb_bridge
  import fta_bus_pkg::*;
#(
  parameter int unsigned WID        = 256,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned TIMEOUT    = 1023,
  parameter bit          ACK_STORES = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  fta_bus_interface.slave   fta_i,
  output logic              cyc_o,
  output logic              stb_o,
  output logic              we_o,
  output logic [WID/8-1:0]  sel_o,
  output logic [31:0]       adr_o,
  output logic [WID-1:0]    dat_o,
  input  logic              ack_i,
  input  logic              err_i,
  input  logic [WID-1:0]    dat_i
);

  localparam int unsigned SELW = WID / 8;
  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned TOW  = $clog2(TIMEOUT + 1);

  fta_wb_state_t        state_q, state_d;
  fta_wb_entry_t        cur_q, cur_d, head, req_entry;
  fta_cmd_response256_t resp_q, resp_d;
  logic                 cyc_q, cyc_d;
  logic [TOW-1:0]       to_q, to_d;
  logic                 full, empty, pop, rty, is_store, timeout_c;
  logic [CW-1:0]        count;

  assign req_entry = fta_wb_entry_from_req(fta_i.req);
  assign pop       = (state_q == IDLE) && !empty;
  assign rty       = fta_i.req.cyc && full && !pop;
  assign is_store  = (cur_q.cmd == CMD_STORE);
  assign timeout_c = ((to_q + TOW'(1)) == TOW'(TIMEOUT));

  fta_wb_req_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fta_wb_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fta_i.req.cyc),
    .din_i   (req_entry),
    .pop_i   (pop),
    .head_c  (head),
    .full_c  (full),
    .empty_c (empty),
    .count_o (count)
  );

  // Next-state and response beat; resp is built on the BUS exit so it lands
  // in the same clock that cyc_o drops.
  always_comb begin
    state_d        = state_q;
    cur_d          = cur_q;
    cyc_d          = cyc_q;
    to_d           = to_q;
    resp_d         = '0;
    resp_d.stall   = (count == CW'(DEPTH));
    resp_d.rty     = rty;
    resp_d.rty_tid = rty ? fta_i.req.tid : '0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          cur_d   = head;
          cyc_d   = 1'b1;
          to_d    = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        to_d = to_q + TOW'(1);
        if (err_i || ack_i || timeout_c) begin
          cyc_d   = 1'b0;
          state_d = RESP;
          if (err_i || !ack_i) begin
            resp_d.err = 1'b1;
            resp_d.tid = cur_q.tid;
            resp_d.adr = cur_q.adr;
          end else if (!is_store || ACK_STORES) begin
            resp_d.ack = 1'b1;
            resp_d.tid = cur_q.tid;
            resp_d.adr = cur_q.adr;
            resp_d.dat = is_store ? '0 : FTA_DW'(dat_i);
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cur_q   <= '0;
      cyc_q   <= 1'b0;
      to_q    <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cyc_q   <= cyc_d;
      to_q    <= to_d;
      resp_q  <= resp_d;
    end
  end

  assign cyc_o      = cyc_q;
  assign stb_o      = cyc_q;
  assign we_o       = cur_q.we;
  assign sel_o      = SELW'(cur_q.sel);
  assign adr_o      = cur_q.adr;
  assign dat_o      = WID'(cur_q.dat);
  assign fta_i.resp = resp_q;

endmodule
